// File: rtl/wb_gpio_evq_pkg.sv
// Shared register map, bit positions and code limits for the pedal event queue.
package wb_gpio_pkg;

  typedef enum logic [1:0] {
    ADR_DATA   = 2'd0,
    ADR_STATUS = 2'd1,
    ADR_CTRL   = 2'd2,
    ADR_LAST   = 2'd3
  } reg_adr_e;

  localparam int DATA_VLD     = 8;
  localparam int ST_EMPTY     = 8;
  localparam int ST_FULL      = 9;
  localparam int ST_OVF       = 10;
  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_OVF_CLR = 1;
  localparam int CTRL_FLUSH   = 2;

  localparam logic [2:0] CODE_MIN = 3'd1;
  localparam logic [2:0] CODE_MAX = 3'd4;

  function automatic logic code_valid(input logic [2:0] code);
    return (code >= CODE_MIN) && (code <= CODE_MAX);
  endfunction

endpackage

// File: rtl/wb_gpio_evq_if.sv
// Wishbone classic slave signal bundle for the pedal event queue.
interface wb_gpio_evq_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_gpio_evq_fifo.sv
// DEPTH x 3 synchronous FIFO with first-word-fall-through output and flush.
module evq_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [2:0]                 din_i,
  output logic [2:0]                 dout_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [2:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rptr_q];

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PTR_W'(1);
      if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/wb_gpio_evq.sv
// Wishbone slave turning debounced button strobes into a CPU-visible event queue
// with status, last-code register and a level interrupt.
module wb_gpio_evq
  import wb_gpio_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [2:0]     outuser,
  input  logic           gpio_en,
  wb_gpio_evq_if.slave   wb,
  output logic           intr
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic             irq_en_q, irq_en_d;
  logic             ovf_q, ovf_d;
  logic [2:0]       last_q, last_d;
  logic             intr_q, intr_d;

  logic             req, rd_req, wr_req;
  reg_adr_e         sel;
  logic             code_ok;
  logic             pop, ctrl_wr, flush, ovf_clr, ovf_set;
  logic [31:0]      rdata;

  logic [2:0]       fifo_dout;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_empty, fifo_full;
  logic             unused_bits;

  assign unused_bits = ^{wb.wb_dat_i[31:3], wb.wb_adr_i[1:0]};

  // A request is taken only while ack is low, so a held strobe alternates.
  assign req     = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign rd_req  = req & ~wb.wb_we_i;
  assign wr_req  = req & wb.wb_we_i;
  assign sel     = reg_adr_e'(wb.wb_adr_i[3:2]);
  assign code_ok = gpio_en & code_valid(outuser);

  assign pop     = rd_req & (sel == ADR_DATA);
  assign ctrl_wr = wr_req & (sel == ADR_CTRL);
  assign flush   = ctrl_wr & wb.wb_dat_i[CTRL_FLUSH];
  assign ovf_clr = ctrl_wr & wb.wb_dat_i[CTRL_OVF_CLR];
  // Overflow only when the event is really lost: no freeing pop, no flush.
  assign ovf_set = code_ok & fifo_full & ~(pop & ~fifo_empty) & ~flush;

  evq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (code_ok),
    .pop_i   (pop),
    .flush_i (flush),
    .din_i   (outuser),
    .dout_o  (fifo_dout),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    rdata = '0;
    case (sel)
      ADR_DATA: begin
        if (!fifo_empty) begin
          rdata[2:0]      = fifo_dout;
          rdata[DATA_VLD] = 1'b1;
        end
      end
      ADR_STATUS: begin
        rdata[CNT_W-1:0] = fifo_cnt;
        rdata[ST_EMPTY]  = fifo_empty;
        rdata[ST_FULL]   = fifo_full;
        rdata[ST_OVF]    = ovf_q;
      end
      ADR_CTRL: rdata[CTRL_IRQ_EN] = irq_en_q;
      ADR_LAST: rdata[2:0] = last_q;
      default:  rdata = '0;
    endcase
  end

  always_comb begin
    ack_d    = req;
    dat_d    = dat_q;
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    last_d   = last_q;
    intr_d   = irq_en_q & ~fifo_empty;
    if (req) dat_d = wb.wb_we_i ? 32'd0 : rdata;
    if (ctrl_wr) irq_en_d = wb.wb_dat_i[CTRL_IRQ_EN];
    if (ovf_set)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    if (code_ok) last_d = outuser;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      last_q   <= '0;
      intr_q   <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      last_q   <= last_d;
      intr_q   <= intr_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign intr        = intr_q;

endmodule

// File: tb/tb_wb_gpio_evq.sv
// Directed bench for wb_gpio_evq: expected read data queued at issue, checked by an ack monitor.
module tb_wb_gpio_evq;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] outuser;
  logic       gpio_en;
  logic       intr;

  wb_gpio_evq_if wb();

  wb_gpio_evq #(.DEPTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .outuser (outuser),
    .gpio_en (gpio_en),
    .wb      (wb),
    .intr    (intr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every ack consumes one queued transaction; reads are compared.
  always @(negedge clk) begin
    if (wb.wb_ack_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.rd) chk(e.nm, wb.wb_dat_o, e.exp);
      end
    end
  end

  task automatic push_exp(input bit rd, input logic [31:0] exp, input string nm);
    exp_t e;
    e.rd = rd; e.exp = exp; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic bus_start(input bit we, input logic [1:0] a, input logic [31:0] d);
    logic [3:0] adr;
    adr = {a, 2'b00};
    @(negedge clk);
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = we;
    wb.wb_adr_i = adr;  wb.wb_dat_i = d;
  endtask

  task automatic bus_end(input string nm);
    @(negedge clk);
    chk({"ack_", nm}, {31'd0, wb.wb_ack_o}, 32'd1);
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    gpio_en = 1'b0;
  endtask

  task automatic wb_read(input logic [1:0] a, input logic [31:0] exp, input string nm);
    push_exp(1'b1, exp, nm);
    bus_start(1'b0, a, 32'd0);
    bus_end(nm);
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d, input string nm);
    push_exp(1'b0, 32'd0, nm);
    bus_start(1'b1, a, d);
    bus_end(nm);
  endtask

  task automatic strobe(input logic [2:0] c);
    @(negedge clk);
    gpio_en = 1'b1; outuser = c;
    @(negedge clk);
    gpio_en = 1'b0;
  endtask

  initial begin
    logic [2:0]  codes6 [6]     = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd6};
    logic [2:0]  fill8  [8]     = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [31:0] drain  [8]     = '{32'h103, 32'h104, 32'h101, 32'h102,
                                    32'h103, 32'h104, 32'h101, 32'h102};

    reset = 1'b1; outuser = '0; gpio_en = 1'b0;
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    wb.wb_adr_i = '0;   wb.wb_dat_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, wb.wb_ack_o}, 32'd0);
    chk("rst_dat", wb.wb_dat_o, 32'd0);
    chk("rst_intr", {31'd0, intr}, 32'd0);
    reset = 1'b0;

    wb_read(2'd1, 32'h100, "status_idle");
    wb_read(2'd0, 32'h000, "data_empty");
    chk("intr_idle", {31'd0, intr}, 32'd0);

    // Valid codes queue; 0 and 6 are ignored.
    foreach (codes6[i]) strobe(codes6[i]);
    wb_read(2'd1, 32'h004, "status_cnt4");
    for (int i = 1; i <= 4; i++) wb_read(2'd0, 32'h100 + 32'(i), "data_seq");
    wb_read(2'd0, 32'h000, "data_after_drain");
    wb_read(2'd3, 32'h004, "last_4");

    // Overflow on a ninth event.
    foreach (fill8[i]) strobe(fill8[i]);
    strobe(3'd3);
    wb_read(2'd1, 32'h608, "status_full_ovf");
    wb_read(2'd3, 32'h003, "last_3");
    wb_read(2'd0, 32'h101, "data_first");
    wb_read(2'd1, 32'h407, "status_cnt7_ovf");
    wb_write(2'd2, 32'h2, "ctrl_ovf_clr");
    wb_read(2'd1, 32'h007, "status_ovf_cleared");

    // Full FIFO: pop coincides with push of code 2.
    strobe(3'd1);
    wb_read(2'd1, 32'h208, "status_full");
    push_exp(1'b1, 32'h102, "data_pop_push");
    bus_start(1'b0, 2'd0, 32'd0);
    gpio_en = 1'b1; outuser = 3'd2;
    bus_end("pop_push");
    wb_read(2'd1, 32'h208, "status_full_no_ovf");
    foreach (drain[i]) wb_read(2'd0, drain[i], "data_drain");
    wb_read(2'd0, 32'h000, "data_drained");

    // Interrupt enable and flush racing a push.
    wb_write(2'd2, 32'h1, "ctrl_irq_en");
    chk("intr_empty", {31'd0, intr}, 32'd0);
    strobe(3'd3);
    chk("intr_lag", {31'd0, intr}, 32'd0);
    @(negedge clk);
    chk("intr_set", {31'd0, intr}, 32'd1);
    push_exp(1'b0, 32'd0, "flush_push");
    bus_start(1'b1, 2'd2, 32'h5);
    gpio_en = 1'b1; outuser = 3'd4;
    bus_end("flush_push");
    @(negedge clk);
    chk("intr_after_flush", {31'd0, intr}, 32'd0);
    wb_read(2'd1, 32'h100, "status_flushed");
    wb_read(2'd2, 32'h001, "ctrl_readback");

    // Reset during an active read, then a held strobe.
    strobe(3'd1);
    strobe(3'd2);
    @(negedge clk);
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0;
    wb.wb_adr_i = 4'h0; reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_ack", {31'd0, wb.wb_ack_o}, 32'd0);
    reset = 1'b0;
    push_exp(1'b1, 32'h0, "held_rd0");
    push_exp(1'b1, 32'h0, "held_rd1");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("held_ack", {31'd0, wb.wb_ack_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    chk("intr_after_rst", {31'd0, intr}, 32'd0);
    wb_read(2'd1, 32'h100, "status_after_rst");
    wb_read(2'd3, 32'h000, "last_after_rst");

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
